pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers of the pipelined core.
- Packed stage structs (if_to_id_t, id_to_ex_t, …) travel as WIDTH-bit payloads.
- Stall maps to out_ready=0 on the consumer side; Flush maps to flush.
- The SKID mode breaks the combinational ready path, so hazard-unit stalls no longer ripple through every stage in one cycle.

---
 rtl/pipe_stage_reg.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake, synchronous flush, saturating drop counter and an optional
// 2-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               SKID        = 1'b1,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic accept;
   logic pop;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   generate
      if (SKID) begin : g_skid
         // State encoding equals the number of held entries.
         localparam logic [1:0] ST_EMPTY = 2'd0;
         localparam logic [1:0] ST_ONE   = 2'd1;
         localparam logic [1:0] ST_FULL  = 2'd2;

         logic [1:0]       state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic [WIDTH-1:0] skid_q, skid_d;
         logic             in_ready_q;

         // Next-state and datapath selection; flush wins over accept/pop.
         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
               ST_EMPTY: begin
                  if (accept) begin
                     state_d = ST_ONE;
                     main_d  = in_data;
                  end
               end
               ST_ONE: begin
                  if (accept && !pop) begin
                     state_d = ST_FULL;
                     skid_d  = in_data;
                  end else if (pop && !accept) begin
                     state_d = ST_EMPTY;
                  end else if (accept && pop) begin
                     main_d  = in_data;
                  end
               end
               ST_FULL: begin
                  if (pop) begin
                     state_d = ST_ONE;
                     main_d  = skid_q;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
            if (flush) begin
               state_d = ST_EMPTY;
               main_d  = RESET_VALUE;
            end
         end

         // Controlled state; in_ready is registered from the next state so
         // out_ready never reaches in_ready combinationally.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_q    <= ST_EMPTY;
               main_q     <= RESET_VALUE;
               in_ready_q <= 1'b0;
            end else begin
               state_q    <= state_d;
               main_q     <= main_d;
               in_ready_q <= (state_d != ST_FULL);
            end
         end

         // Skid payload is only meaningful in FULL, so it needs no reset.
         always_ff @(posedge clk) begin
            skid_q <= skid_d;
         end

         assign in_ready  = in_ready_q;
         assign out_valid = (state_q != ST_EMPTY);
         assign out_data  = main_q;
         assign occupancy = state_q;
      end else begin : g_single
         logic             valid_q, valid_d;
         logic [WIDTH-1:0] main_q, main_d;

         // Load on accept, drain on pop without accept; flush empties.
         always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (accept) begin
               valid_d = 1'b1;
               main_d  = in_data;
            end else if (pop) begin
               valid_d = 1'b0;
            end
            if (flush) begin
               valid_d = 1'b0;
               main_d  = RESET_VALUE;
            end
         end

         // Single holding register.
         always_ff @(posedge clk) begin
            if (reset) begin
               valid_q <= 1'b0;
               main_q  <= RESET_VALUE;
            end else begin
               valid_q <= valid_d;
               main_q  <= main_d;
            end
         end

         assign in_ready  = !reset && (!valid_q || out_ready);
         assign out_valid = valid_q;
         assign out_data  = main_q;
         assign occupancy = {1'b0, valid_q};
      end
   endgenerate

   // Drop accounting: entries held minus the one popped, plus the one
   // accepted in the flush cycle. Two guard bits keep the sum exact.
   logic [2:0]       drop_inc;
   logic [CNT_W+1:0] drop_sum;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;

   // Saturating increment of the drop counter on flush.
   always_comb begin
      drop_inc     = 3'(occupancy) - 3'(pop) + 3'(accept);
      drop_sum     = (CNT_W+2)'(drop_count_q) + (CNT_W+2)'(drop_inc);
      drop_count_d = drop_count_q;
      if (flush) begin
         if (drop_sum > (CNT_W+2)'(CNT_MAX)) begin
            drop_count_d = CNT_MAX;
         end else begin
            drop_count_d = drop_sum[CNT_W-1:0];
         end
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count_q <= '0;
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one SKID=1/CNT_W=2 instance and
// one SKID=0/CNT_W=16 instance, checked against a queue-based model.
module tb_pipe_stage_reg;

   localparam logic [31:0] S_RV = 32'hC0DE_0001;
   localparam logic [31:0] N_RV = 32'hDEAD_BEEF;

   logic        clk;
   logic        reset;

   logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [31:0] s_in_data, s_out_data;
   logic [1:0]  s_occ;
   logic [1:0]  s_drop;

   logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [31:0] n_in_data, n_out_data;
   logic [1:0]  n_occ;
   logic [15:0] n_drop;

   int unsigned tests_run;
   int unsigned tests_failed;

   // Reference model state
   logic [31:0] sq[$];
   logic [31:0] nq[$];
   int unsigned s_drops, n_drops;
   bit          s_rdy, s_clean, n_clean;

   pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(S_RV), .SKID(1'b1), .CNT_W(2)) u_dut_skid (
      .clk(clk), .reset(reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occ), .drop_count(s_drop)
   );

   pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(N_RV), .SKID(1'b0), .CNT_W(16)) u_dut_single (
      .clk(clk), .reset(reset), .flush(n_flush),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
      .occupancy(n_occ), .drop_count(n_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit n_exp_rdy();
      return !reset && (nq.size() == 0 || n_out_ready);
   endfunction

   // Advance one clock and update the model from the inputs currently driven.
   task automatic tick();
      bit s_acc, s_pop, n_acc, n_pop;
      int unsigned inc;
      s_acc = s_in_valid && s_rdy;
      s_pop = (sq.size() != 0) && s_out_ready;
      n_acc = n_in_valid && n_exp_rdy();
      n_pop = (nq.size() != 0) && n_out_ready;
      @(posedge clk);
      if (reset) begin
         sq.delete(); nq.delete();
         s_drops = 0; n_drops = 0;
         s_rdy = 1'b0; s_clean = 1'b1; n_clean = 1'b1;
      end else begin
         if (s_flush) begin
            inc = sq.size() - int'(s_pop) + int'(s_acc);
            s_drops = (s_drops + inc > 3) ? 3 : s_drops + inc;
            sq.delete();
            s_clean = 1'b1;
         end else begin
            if (s_pop) void'(sq.pop_front());
            if (s_acc) begin
               sq.push_back(s_in_data);
               s_clean = 1'b0;
            end
         end
         s_rdy = (sq.size() < 2);
         if (n_flush) begin
            inc = nq.size() - int'(n_pop) + int'(n_acc);
            n_drops = (n_drops + inc > 65535) ? 65535 : n_drops + inc;
            nq.delete();
            n_clean = 1'b1;
         end else begin
            if (n_pop) void'(nq.pop_front());
            if (n_acc) begin
               nq.push_back(n_in_data);
               n_clean = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;
      n_flush = 0; n_in_valid = 0; n_out_ready = 0; n_in_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      s_in_valid = 1; s_flush = 1; n_in_valid = 1; n_flush = 1;
      tick();
      tick();
      #1;
      tests_run++;
      if (s_occ !== 2'd0) begin tests_failed++; $display("FAIL reset_s_occ got %0d exp 0", s_occ); end
      tests_run++;
      if (s_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_s_valid got %b exp 0", s_out_valid); end
      tests_run++;
      if (s_out_data !== S_RV) begin tests_failed++; $display("FAIL reset_s_data got %h exp %h", s_out_data, S_RV); end
      tests_run++;
      if (s_drop !== 2'd0) begin tests_failed++; $display("FAIL reset_s_drop got %0d exp 0", s_drop); end
      tests_run++;
      if (s_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got %b exp 0", s_in_ready); end
      tests_run++;
      if (n_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_n_ready got %b exp 0", n_in_ready); end
      tests_run++;
      if (n_out_valid !== 1'b0 || n_occ !== 2'd0 || n_drop !== 16'd0 || n_out_data !== N_RV) begin
         tests_failed++;
         $display("FAIL reset_n_state got v=%b occ=%0d drop=%0d data=%h exp v=0 occ=0 drop=0 data=%h",
                  n_out_valid, n_occ, n_drop, n_out_data, N_RV);
      end
      idle_inputs();
      reset = 1'b0;
      #1;
      tests_run++;
      if (s_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready_deassert got %b exp 0", s_in_ready); end
      tests_run++;
      if (n_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_n_ready_deassert got %b exp 1", n_in_ready); end
      tick();
      #1;
      tests_run++;
      if (s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready_after got %b exp 1", s_in_ready); end
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 16; i++) begin
         s_in_valid = 1; s_in_data = 32'(i); s_out_ready = 1;
         n_in_valid = 1; n_in_data = 32'(i); n_out_ready = 1;
         #1;
         tests_run++;
         if (s_in_ready !== 1'b1 || s_occ > 2'd1) begin
            tests_failed++;
            $display("FAIL stream_s_ready i=%0d got ready=%b occ=%0d exp ready=1 occ<=1", i, s_in_ready, s_occ);
         end
         tests_run++;
         if (n_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_n_ready i=%0d got %b exp 1", i, n_in_ready); end
         if (i > 1) begin
            tests_run++;
            if (s_out_valid !== 1'b1 || s_out_data !== 32'(i - 1)) begin
               tests_failed++;
               $display("FAIL stream_s_data i=%0d got v=%b d=%h exp v=1 d=%h", i, s_out_valid, s_out_data, 32'(i - 1));
            end
            tests_run++;
            if (n_out_valid !== 1'b1 || n_out_data !== 32'(i - 1)) begin
               tests_failed++;
               $display("FAIL stream_n_data i=%0d got v=%b d=%h exp v=1 d=%h", i, n_out_valid, n_out_data, 32'(i - 1));
            end
         end
         tick();
      end
      s_in_valid = 0; n_in_valid = 0;
      #1;
      tests_run++;
      if (s_out_data !== 32'h10 || n_out_data !== 32'h10) begin
         tests_failed++;
         $display("FAIL stream_last got s=%h n=%h exp 00000010", s_out_data, n_out_data);
      end
      tick();
      #1;
      tests_run++;
      if (s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_drain got s=%b n=%b exp 0", s_out_valid, n_out_valid);
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      logic [31:0] vals[$];
      logic [31:0] got[$];
      int idx;
      vals = '{32'hA, 32'hB, 32'hC};
      idx = 0;
      idle_inputs();
      for (int cyc = 0; cyc < 10; cyc++) begin
         s_in_valid  = (idx < 3);
         s_in_data   = (idx < 3) ? vals[idx] : '0;
         s_out_ready = (cyc >= 5);
         #1;
         tests_run++;
         if (s_in_ready !== s_rdy) begin
            tests_failed++;
            $display("FAIL bp_ready cyc=%0d got %b exp %b", cyc, s_in_ready, s_rdy);
         end
         if (cyc >= 2 && cyc < 5) begin
            tests_run++;
            if (s_occ !== 2'd2 || s_in_ready !== 1'b0 || s_out_data !== 32'hA) begin
               tests_failed++;
               $display("FAIL bp_stall cyc=%0d got occ=%0d ready=%b d=%h exp occ=2 ready=0 d=0000000a",
                        cyc, s_occ, s_in_ready, s_out_data);
            end
         end
         if (cyc == 5 || cyc == 6) begin
            tests_run++;
            if (s_in_ready !== (cyc == 6)) begin
               tests_failed++;
               $display("FAIL bp_ready_rise cyc=%0d got %b exp %b", cyc, s_in_ready, cyc == 6);
            end
         end
         if (s_out_valid && s_out_ready) got.push_back(s_out_data);
         if (s_in_valid && s_in_ready) idx++;
         tick();
      end
      tests_run++;
      if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
         tests_failed++;
         $display("FAIL bp_order got %p exp A,B,C", got);
      end
      idle_inputs();
   endtask

   task automatic test_flush_full_pop();
      do_reset();
      s_in_valid = 1; s_in_data = 32'hA; tick();
      s_in_data = 32'hB; tick();
      s_in_valid = 0;
      #1;
      tests_run++;
      if (s_occ !== 2'd2) begin tests_failed++; $display("FAIL ffp_full got %0d exp 2", s_occ); end
      s_flush = 1; s_out_ready = 1;
      #1;
      tests_run++;
      if (s_out_data !== 32'hA || s_out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL ffp_pop got v=%b d=%h exp v=1 d=0000000a", s_out_valid, s_out_data);
      end
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (s_out_valid !== 1'b0 || s_out_data !== S_RV || s_in_ready !== 1'b1 || s_occ !== 2'd0) begin
         tests_failed++;
         $display("FAIL ffp_after got v=%b d=%h ready=%b occ=%0d exp v=0 d=%h ready=1 occ=0",
                  s_out_valid, s_out_data, s_in_ready, s_occ, S_RV);
      end
      tests_run++;
      if (s_drop !== 2'd1) begin tests_failed++; $display("FAIL ffp_drop got %0d exp 1", s_drop); end
   endtask

   task automatic test_flush_accept_single();
      do_reset();
      n_in_valid = 1; n_in_data = 32'h5; tick();
      n_in_data = 32'h6; n_out_ready = 1; n_flush = 1;
      #1;
      tests_run++;
      if (n_in_ready !== 1'b1 || n_out_data !== 32'h5 || n_out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL fa_cycle got ready=%b v=%b d=%h exp ready=1 v=1 d=00000005",
                  n_in_ready, n_out_valid, n_out_data);
      end
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (n_out_valid !== 1'b0 || n_out_data !== N_RV || n_occ !== 2'd0) begin
         tests_failed++;
         $display("FAIL fa_after got v=%b d=%h occ=%0d exp v=0 d=%h occ=0", n_out_valid, n_out_data, n_occ, N_RV);
      end
      tests_run++;
      if (n_drop !== 16'd1) begin tests_failed++; $display("FAIL fa_drop got %0d exp 1", n_drop); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_tbl [5];
      exp_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         s_in_valid = 1; s_in_data = $urandom; s_out_ready = 0;
         tick();
         s_in_valid = 0; s_flush = 1;
         tick();
         s_flush = 0;
         #1;
         tests_run++;
         if (s_drop !== exp_tbl[k]) begin
            tests_failed++;
            $display("FAIL sat_drop k=%0d got %0d exp %0d", k, s_drop, exp_tbl[k]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      s_in_valid = 1; s_in_data = 32'hA; tick();
      s_in_data = 32'hB; tick();
      reset = 1; s_flush = 1; s_in_data = 32'hC;
      tick();
      #1;
      tests_run++;
      if (s_occ !== 2'd0 || s_drop !== 2'd0 || s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rm_during got occ=%0d drop=%0d ready=%b v=%b exp 0 0 0 0",
                  s_occ, s_drop, s_in_ready, s_out_valid);
      end
      reset = 0;
      idle_inputs();
      tick();
      #1;
      tests_run++;
      if (s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_ready got %b exp 1", s_in_ready); end
      s_in_valid = 1; s_in_data = 32'h77;
      tick();
      s_in_valid = 0;
      #1;
      tests_run++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'h77) begin
         tests_failed++;
         $display("FAIL rm_data got v=%b d=%h exp v=1 d=00000077", s_out_valid, s_out_data);
      end
      tick();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset       = ($urandom_range(63) == 0);
         s_in_valid  = ($urandom_range(3) != 0);
         s_in_data   = $urandom;
         s_out_ready = ($urandom_range(2) != 0);
         s_flush     = ($urandom_range(15) == 0);
         n_in_valid  = ($urandom_range(3) != 0);
         n_in_data   = $urandom;
         n_out_ready = ($urandom_range(2) != 0);
         n_flush     = ($urandom_range(15) == 0);
         #1;
         tests_run++;
         if (s_in_ready !== s_rdy || s_out_valid !== (sq.size() != 0) || s_occ !== 2'(sq.size())
             || s_drop !== 2'(s_drops)) begin
            tests_failed++;
            $display("FAIL rnd_s_ctrl cyc=%0d got ready=%b v=%b occ=%0d drop=%0d exp ready=%b v=%b occ=%0d drop=%0d",
                     cyc, s_in_ready, s_out_valid, s_occ, s_drop, s_rdy, sq.size() != 0, sq.size(), s_drops);
         end
         if (sq.size() != 0 || s_clean) begin
            tests_run++;
            if (s_out_data !== ((sq.size() != 0) ? sq[0] : S_RV)) begin
               tests_failed++;
               $display("FAIL rnd_s_data cyc=%0d got %h exp %h", cyc, s_out_data, (sq.size() != 0) ? sq[0] : S_RV);
            end
         end
         tests_run++;
         if (n_in_ready !== n_exp_rdy() || n_out_valid !== (nq.size() != 0) || n_occ !== 2'(nq.size())
             || n_drop !== 16'(n_drops)) begin
            tests_failed++;
            $display("FAIL rnd_n_ctrl cyc=%0d got ready=%b v=%b occ=%0d drop=%0d exp ready=%b v=%b occ=%0d drop=%0d",
                     cyc, n_in_ready, n_out_valid, n_occ, n_drop, n_exp_rdy(), nq.size() != 0, nq.size(), n_drops);
         end
         if (nq.size() != 0 || n_clean) begin
            tests_run++;
            if (n_out_data !== ((nq.size() != 0) ? nq[0] : N_RV)) begin
               tests_failed++;
               $display("FAIL rnd_n_data cyc=%0d got %h exp %h", cyc, n_out_data, (nq.size() != 0) ? nq[0] : N_RV);
            end
         end
         tick();
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      s_rdy = 0; s_clean = 1; n_clean = 1; s_drops = 0; n_drops = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_full_pop();
      test_flush_accept_single();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
